// File: rtl/conv_window_buf_if.sv
// Stream bundle for conv_window_buf.
// Pixel side: valid_in / ready_in / pixel_in.
// Window side: valid_out / ready_out / win_out / out_last.
// Modport slave is the block's view. Modport master is the view of the surrounding logic.
interface conv_window_buf_if #(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned KSIZE  = 3
);
    localparam int unsigned WIN_W = KSIZE * KSIZE * DATA_W;

    logic              valid_in;
    logic              ready_in;
    logic [DATA_W-1:0] pixel_in;
    logic              valid_out;
    logic              ready_out;
    logic [WIN_W-1:0]  win_out;
    logic              out_last;

    modport slave (
        input  valid_in, pixel_in, ready_out,
        output ready_in, valid_out, win_out, out_last
    );

    modport master (
        output valid_in, pixel_in, ready_out,
        input  ready_in, valid_out, win_out, out_last
    );
endinterface

// File: rtl/conv_window_buf.sv
// K x K sliding-window generator over a raster pixel stream, with a configurable stride.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - synchronous active-low reset
//   sync_clr - synchronous frame restart. It drops any pending window.
//   bus      - pixel-in and window-out valid/ready handshakes (conv_window_buf_if.slave)
// The output has a single stage with no skid buffer.
// ready_in is combinational from valid_out, ready_out, rst_n and sync_clr.
module conv_window_buf #(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned WIDTH  = 28,
    parameter int unsigned HEIGHT = 28,
    parameter int unsigned KSIZE  = 3,
    parameter int unsigned STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_clr,
    conv_window_buf_if.slave bus
);
    localparam int unsigned XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned RN     = KSIZE - 1;
    localparam int unsigned PW     = (RN > 1) ? $clog2(RN) : 1;
    localparam int unsigned PW1    = PW + 1;
    localparam int unsigned SW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int unsigned WIN_W  = KSIZE * KSIZE * DATA_W;
    localparam int unsigned LAST_X = WIDTH - 1 - ((WIDTH - KSIZE) % STRIDE);
    localparam int unsigned LAST_Y = HEIGHT - 1 - ((HEIGHT - KSIZE) % STRIDE);

    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [PW-1:0]     wptr;
    logic [SW-1:0]     px;
    logic [SW-1:0]     py;
    logic [DATA_W-1:0] line_mem [RN][WIDTH];
    logic [DATA_W-1:0] win      [KSIZE][KSIZE];
    logic [DATA_W-1:0] win_next [KSIZE][KSIZE];
    logic [WIN_W-1:0]  win_flat;
    logic [WIN_W-1:0]  win_q;
    logic              valid_q;
    logic              last_q;
    logic              ready_c;
    logic              accept;
    logic              x_end;
    logic              y_end;
    logic              emit;
    logic              emit_last;

    // Slot holding row (y - RN + off). Slot wptr still holds the oldest row, so it is read before being overwritten.
    function automatic logic [PW-1:0] row_slot(input logic [PW-1:0] base, input int unsigned off);
        logic [PW1-1:0] sum;
        sum = {1'b0, base} + PW1'(off);
        if (sum >= PW1'(RN)) begin
            sum = sum - PW1'(RN);
        end
        return sum[PW-1:0];
    endfunction

    assign ready_c   = rst_n && !sync_clr && (!valid_q || bus.ready_out);
    assign accept    = bus.valid_in && ready_c;
    assign x_end     = (x == XW'(WIDTH - 1));
    assign y_end     = (y == YW'(HEIGHT - 1));
    assign emit      = accept && (x >= XW'(KSIZE - 1)) && (y >= YW'(KSIZE - 1))
                       && (px == '0) && (py == '0);
    assign emit_last = (x == XW'(LAST_X)) && (y == YW'(LAST_Y));

    // Shift the window left and build the new right column from the line rows, oldest first, with pixel_in at the bottom.
    always_comb begin
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE - 1; c++) begin
                win_next[r][c] = win[r][c+1];
            end
            if (r == KSIZE - 1) begin
                win_next[r][KSIZE-1] = bus.pixel_in;
            end else begin
                win_next[r][KSIZE-1] = line_mem[row_slot(wptr, r)][x];
            end
        end
    end

    // Flatten the window: element (r,c) sits at bit offset (r*KSIZE+c)*DATA_W.
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                win_flat[(r*KSIZE+c)*DATA_W +: DATA_W] = win_next[r][c];
            end
        end
    end

    // Position counters. A phase counter restarts once the position reaches KSIZE-1 and then counts modulo STRIDE.
    always_ff @(posedge clk) begin
        if (!rst_n || sync_clr) begin
            x    <= '0;
            y    <= '0;
            wptr <= '0;
            px   <= '0;
            py   <= '0;
        end else if (accept) begin
            if (x_end) begin
                x  <= '0;
                px <= '0;
                if (y_end) begin
                    y    <= '0;
                    py   <= '0;
                    wptr <= '0;
                end else begin
                    y    <= y + 1'b1;
                    wptr <= (wptr == PW'(RN - 1)) ? '0 : wptr + 1'b1;
                    py   <= ((y < YW'(KSIZE - 1)) || (py == SW'(STRIDE - 1))) ? '0 : py + 1'b1;
                end
            end else begin
                x  <= x + 1'b1;
                px <= ((x < XW'(KSIZE - 1)) || (px == SW'(STRIDE - 1))) ? '0 : px + 1'b1;
            end
        end
    end

    // Line rows and window register. Stale contents are never emitted, so these have no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_mem[wptr][x] <= bus.pixel_in;
            win               <= win_next;
        end
    end

    // Output stage. A new emit takes priority over draining.
    always_ff @(posedge clk) begin
        if (!rst_n || sync_clr) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            win_q   <= '0;
        end else if (emit) begin
            valid_q <= 1'b1;
            last_q  <= emit_last;
            win_q   <= win_flat;
        end else if (bus.ready_out) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign bus.ready_in  = ready_c;
    assign bus.valid_out = valid_q;
    assign bus.win_out   = win_q;
    assign bus.out_last  = last_q;
endmodule

// File: tb/tb_conv_window_buf.sv
// Directed bench for conv_window_buf.
// Three instances:
//   u_s1 - 5x5 image, K=3, S=1
//   u_s2 - 5x5 image, K=3, S=2
//   u_k5 - 9x7 image, K=5, S=2, 4-bit pixels
// Expected windows are built directly from the image array.
module tb_conv_window_buf;
    logic clk;
    logic rst_n;
    logic tb_valid;
    logic tb_ready;
    logic clr;
    logic [7:0] tb_pixel;
    int sel;
    int cw, ch, ck, cs, cd;
    int checks = 0;
    int errors = 0;
    int img [0:255];
    logic [199:0] exp_win_q [$];
    logic         exp_last_q [$];
    logic [199:0] cur_win;
    logic         cur_valid;
    logic         cur_last;
    logic         cur_ready;

    conv_window_buf_if #(.DATA_W(8), .KSIZE(3)) if_s1 ();
    conv_window_buf_if #(.DATA_W(8), .KSIZE(3)) if_s2 ();
    conv_window_buf_if #(.DATA_W(4), .KSIZE(5)) if_k5 ();

    conv_window_buf #(.DATA_W(8), .WIDTH(5), .HEIGHT(5), .KSIZE(3), .STRIDE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .sync_clr(clr && sel == 0), .bus(if_s1.slave));
    conv_window_buf #(.DATA_W(8), .WIDTH(5), .HEIGHT(5), .KSIZE(3), .STRIDE(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .sync_clr(clr && sel == 1), .bus(if_s2.slave));
    conv_window_buf #(.DATA_W(4), .WIDTH(9), .HEIGHT(7), .KSIZE(5), .STRIDE(2)) u_k5 (
        .clk(clk), .rst_n(rst_n), .sync_clr(clr && sel == 2), .bus(if_k5.slave));

    assign if_s1.valid_in  = tb_valid && (sel == 0);
    assign if_s1.pixel_in  = tb_pixel;
    assign if_s1.ready_out = (sel == 0) ? tb_ready : 1'b1;
    assign if_s2.valid_in  = tb_valid && (sel == 1);
    assign if_s2.pixel_in  = tb_pixel;
    assign if_s2.ready_out = (sel == 1) ? tb_ready : 1'b1;
    assign if_k5.valid_in  = tb_valid && (sel == 2);
    assign if_k5.pixel_in  = tb_pixel[3:0];
    assign if_k5.ready_out = (sel == 2) ? tb_ready : 1'b1;

    always_comb begin
        cur_win   = 200'(if_s1.win_out);
        cur_valid = if_s1.valid_out;
        cur_last  = if_s1.out_last;
        cur_ready = if_s1.ready_in;
        if (sel == 1) begin
            cur_win   = 200'(if_s2.win_out);
            cur_valid = if_s2.valid_out;
            cur_last  = if_s2.out_last;
            cur_ready = if_s2.ready_in;
        end else if (sel == 2) begin
            cur_win   = 200'(if_k5.win_out);
            cur_valid = if_k5.valid_out;
            cur_last  = if_k5.out_last;
            cur_ready = if_k5.ready_in;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected windows of one frame whose pixels start at img[base], in raster order of top-left corner.
    task automatic build_frame(input int base);
        logic [199:0] w;
        for (int y0 = 0; y0 + ck <= ch; y0 += cs) begin
            for (int x0 = 0; x0 + ck <= cw; x0 += cs) begin
                w = '0;
                for (int r = 0; r < ck; r++)
                    for (int c = 0; c < ck; c++)
                        for (int b = 0; b < cd; b++)
                            w[(r*ck+c)*cd+b] = 1'(img[base + (y0+r)*cw + x0 + c] >> b);
                exp_win_q.push_back(w);
                exp_last_q.push_back((y0 + ck + cs > ch) && (x0 + ck + cs > cw));
            end
        end
    endtask

    // Stream img[0..n_px-1] into the selected instance and score every window handed over.
    task automatic send_stream(input string tag, input int n_px, input int vgap, input int rgap,
                               input int stall_len, input int first_px);
        int idx = 0;
        int prev_acc = -1;
        int stall_left = 0;
        int budget = 0;
        int got = 0;
        int expn;
        bit first_seen = 1'b0;
        logic [199:0] held = '0;
        expn = exp_win_q.size();
        while ((idx < n_px || exp_win_q.size() > 0) && budget < 4000) begin
            budget++;
            if (cur_valid && !first_seen) begin
                first_seen = 1'b1;
                chk({tag, " first window latency"}, 200'(prev_acc), 200'(first_px));
                if (stall_len > 0) begin
                    stall_left = stall_len;
                    held = cur_win;
                end
            end
            tb_valid = (idx < n_px) && (int'($urandom_range(99)) >= vgap);
            tb_pixel = 8'(img[idx]);
            tb_ready = (stall_left > 0) ? 1'b0 : (int'($urandom_range(99)) >= rgap);
            #1;
            if (stall_left > 0) begin
                chk({tag, " stall valid_out"}, 200'(cur_valid), 200'(1));
                chk({tag, " stall win_out held"}, cur_win, held);
                chk({tag, " stall ready_in"}, 200'(cur_ready), 200'(0));
            end
            if (cur_valid && tb_ready) begin
                got++;
                if (exp_win_q.size() == 0) begin
                    chk({tag, " surplus window count"}, 200'(got), 200'(expn));
                end else begin
                    chk({tag, " win_out"}, cur_win, exp_win_q.pop_front());
                    chk({tag, " out_last"}, 200'(cur_last), 200'(exp_last_q.pop_front()));
                end
            end
            if (tb_valid && cur_ready) begin
                prev_acc = idx;
                idx++;
            end else begin
                prev_acc = -1;
            end
            @(posedge clk);
            #1;
            if (stall_left > 0) stall_left--;
        end
        tb_valid = 1'b0;
        tb_ready = 1'b1;
        chk({tag, " window count"}, 200'(got), 200'(expn));
        chk({tag, " idle after stream"}, 200'(cur_valid), 200'(0));
        exp_win_q.delete();
        exp_last_q.delete();
    endtask

    // Push n pixels with the current tb_ready, no scoring.
    task automatic push_raw(input int n);
        for (int i = 0; i < n; i++) begin
            tb_valid = 1'b1;
            tb_pixel = 8'(img[i]);
            @(posedge clk);
            #1;
        end
        tb_valid = 1'b0;
    endtask

    task automatic ramp_image();
        for (int i = 0; i < 25; i++) begin
            img[i]      = i;
            img[25 + i] = 100 + i;
        end
    endtask

    initial begin
        sel = 0; cw = 5; ch = 5; ck = 3; cs = 1; cd = 8;
        tb_valid = 1'b0; tb_ready = 1'b1; tb_pixel = '0; clr = 1'b0; rst_n = 1'b0;
        ramp_image();
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready_in", 200'(cur_ready), 200'(0));
        chk("reset valid_out", 200'(cur_valid), 200'(0));
        chk("reset win_out", cur_win, 200'(0));
        chk("reset out_last", 200'(cur_last), 200'(0));
        rst_n = 1'b1;
        #1;
        chk("ready_in after reset", 200'(cur_ready), 200'(1));
        @(posedge clk);
        #1;

        // Stride 1, no gaps.
        build_frame(0);
        send_stream("s1", 25, 0, 0, 0, 12);

        // Ten-cycle stall right after the first window.
        build_frame(0);
        send_stream("bp", 25, 0, 0, 10, 12);

        // Two frames back to back.
        build_frame(0);
        build_frame(25);
        send_stream("b2b", 50, 0, 0, 0, 12);

        // sync_clr after 7 pixels. A pixel is offered during the clear.
        push_raw(7);
        tb_valid = 1'b1;
        tb_pixel = 8'hAA;
        clr = 1'b1;
        #1;
        chk("sclr ready_in", 200'(cur_ready), 200'(0));
        @(posedge clk);
        #1;
        clr = 1'b0;
        tb_valid = 1'b0;
        chk("sclr valid_out", 200'(cur_valid), 200'(0));
        build_frame(0);
        send_stream("sclr", 25, 0, 0, 0, 12);

        // sync_clr drops a window that is held under backpressure.
        tb_ready = 1'b0;
        push_raw(13);
        chk("pending valid_out", 200'(cur_valid), 200'(1));
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("sclr pending valid_out", 200'(cur_valid), 200'(0));
        chk("sclr pending out_last", 200'(cur_last), 200'(0));
        tb_ready = 1'b1;
        build_frame(0);
        send_stream("sclr2", 25, 0, 0, 0, 12);

        // Reset while a window is pending.
        tb_ready = 1'b0;
        push_raw(13);
        chk("pre-reset valid_out", 200'(cur_valid), 200'(1));
        rst_n = 1'b0;
        #1;
        chk("in-reset ready_in", 200'(cur_ready), 200'(0));
        @(posedge clk);
        #1;
        chk("mid reset valid_out", 200'(cur_valid), 200'(0));
        chk("mid reset win_out", cur_win, 200'(0));
        chk("mid reset out_last", 200'(cur_last), 200'(0));
        rst_n = 1'b1;
        tb_ready = 1'b1;
        build_frame(0);
        send_stream("post_rst", 25, 0, 0, 0, 12);

        // Stride 2: top-left corners 0, 2, 10, 12.
        sel = 1; cs = 2;
        build_frame(0);
        send_stream("s2", 25, 0, 0, 0, 12);
        build_frame(0);
        send_stream("s2 gaps", 25, 40, 40, 0, 12);

        // K=5, 4-bit random pixels, two frames, random gaps on both sides.
        sel = 2; cw = 9; ch = 7; ck = 5; cs = 2; cd = 4;
        for (int i = 0; i < 126; i++) img[i] = int'($urandom_range(15));
        build_frame(0);
        build_frame(63);
        send_stream("k5", 126, 30, 30, 0, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
